// File: rtl/meio_somador_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | meio_somador_pkg : shared mode encodings and counter default.     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package meio_somador_pkg;

    localparam logic MODE_LANES    = 1'b0;
    localparam logic MODE_CHAIN    = 1'b1;
    localparam int   CNT_W_DEFAULT = 16;

endpackage : meio_somador_pkg
`default_nettype wire

// File: rtl/meio_somador_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | meio_somador_if : operand/result bundle for the half-adder block. |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface meio_somador_if
    import meio_somador_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = CNT_W_DEFAULT
);
    logic             in_valid;
    logic             mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] C;
    logic             out_valid;
    logic [CNT_W-1:0] carry_cnt;

    modport master (
        output in_valid, mode, A, B,
        input  S, C, out_valid, carry_cnt
    );

    modport slave (
        input  in_valid, mode, A, B,
        output S, C, out_valid, carry_cnt
    );
endinterface : meio_somador_if
`default_nettype wire

// File: rtl/meio_somador_cell.sv
`default_nettype none
// +------------------------------------------------------------------+
// | half_adder_cell : one lane; cin only participates when chained.   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module half_adder_cell (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    input  wire logic chain_en,
    output logic      s,
    output logic      cout
);
    logic w_cin_eff;
    logic w_prop;

    assign w_cin_eff = cin & chain_en;
    assign w_prop    = a ^ b;
    assign s         = w_prop ^ w_cin_eff;
    assign cout      = (a & b) | (w_prop & w_cin_eff);
endmodule : half_adder_cell
`default_nettype wire

// File: rtl/meio_somador.sv
`default_nettype none
// +------------------------------------------------------------------+
// | meio_somador : registered lane-parallel half adder, optional      |
// | ripple chaining, saturating carry-event counter.    Rev 1.0       |
// +------------------------------------------------------------------+
module meio_somador
    import meio_somador_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    meio_somador_if.slave      bus
);
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_c;
    logic             w_chain_en;

    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_c;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;

    assign w_chain_en = (bus.mode == MODE_CHAIN);

    // Each lane owns its carry nets so the ripple is a plain chain of scalars.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            logic w_cin;
            logic w_cout;
            logic w_sum;

            if (i == 0) begin : g_first
                assign w_cin = 1'b0;
            end else begin : g_rest
                assign w_cin = g_lane[i-1].w_cout;
            end

            half_adder_cell u_cell (
                .a        (bus.A[i]),
                .b        (bus.B[i]),
                .cin      (w_cin),
                .chain_en (w_chain_en),
                .s        (w_sum),
                .cout     (w_cout)
            );

            assign w_s[i] = w_sum;
            assign w_c[i] = w_cout;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s     <= '0;
            r_c     <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s <= w_s;
                r_c <= w_c;
                if ((|w_c) && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.S         = r_s;
    assign bus.C         = r_c;
    assign bus.out_valid = r_valid;
    assign bus.carry_cnt = r_cnt;
endmodule : meio_somador
`default_nettype wire

// File: tb/tb_meio_somador.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_meio_somador : table vectors, corner sequences and random      |
// | traffic against an arithmetic reference model.     Rev 1.0        |
// +------------------------------------------------------------------+
module tb_meio_somador;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    meio_somador_if #(.WIDTH(4), .CNT_W(16)) bus4 ();
    meio_somador_if #(.WIDTH(1), .CNT_W(16)) bus1 ();
    meio_somador_if #(.WIDTH(1), .CNT_W(2))  buss ();

    meio_somador #(.WIDTH(4), .CNT_W(16)) u_w4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    meio_somador #(.WIDTH(1), .CNT_W(16)) u_w1  (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    meio_somador #(.WIDTH(1), .CNT_W(2))  u_sat (.clk(clk), .rst_n(rst_n), .bus(buss.slave));

    typedef struct {
        logic        rst_n;
        logic        in_valid;
        logic        mode;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  exp_s;
        logic [3:0]  exp_c;
        logic        exp_ov;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: S is (A+B) truncated; each chained carry bit is the carry out
    // of the i+1 low bits added as integers.
    function automatic logic [127:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                             input logic mode, input int w);
        logic [64:0] mask;
        logic [64:0] sum;
        logic [63:0] s;
        logic [63:0] c;
        s = '0;
        c = '0;
        mask = (65'd1 << w) - 65'd1;
        if (mode) begin
            sum = ({1'b0, a} + {1'b0, b}) & mask;
            s   = sum[63:0];
            for (int i = 0; i < w; i++) begin
                logic [64:0] m;
                logic [64:0] part;
                m    = (65'd1 << (i + 1)) - 65'd1;
                part = ({1'b0, a} & m) + ({1'b0, b} & m);
                c[i] = part[i+1];
            end
        end else begin
            s = (a ^ b) & mask[63:0];
            c = (a & b) & mask[63:0];
        end
        return {c, s};
    endfunction

    initial begin
        logic [1:0]  pairs_ab[4];
        logic        exp1_s[4];
        logic        exp1_c[4];
        logic [3:0]  m4_s, m4_c;
        logic        m4_ov;
        int          m4_cnt;
        logic        m1_s, m1_c, m1_ov;
        int          m1_cnt;
        logic [127:0] r;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 4'b0111, 4'b0001, 4'b0110, 4'b0001, 1'b1, 16'd1};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 4'b0111, 4'b0001, 4'b1000, 4'b0111, 1'b1, 16'd2};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 4'b1111, 4'b0001, 4'b0000, 4'b1111, 1'b1, 16'd3};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 4'b1010, 4'b0110, 4'b0000, 4'b1111, 1'b0, 16'd3};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 1'b0, 16'd3};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 4'b0011, 4'b0101, 4'b0000, 4'b1111, 1'b0, 16'd3};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 4'b0101, 4'b1010, 4'b1111, 4'b0000, 1'b1, 16'd3};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 16'd0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 16'd0};

        pairs_ab = '{2'b00, 2'b01, 2'b10, 2'b11};
        exp1_s   = '{1'b0, 1'b1, 1'b1, 1'b0};
        exp1_c   = '{1'b0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        bus4.in_valid = 1'b0; bus4.mode = 1'b0; bus4.A = '0; bus4.B = '0;
        bus1.in_valid = 1'b0; bus1.mode = 1'b0; bus1.A = '0; bus1.B = '0;
        buss.in_valid = 1'b0; buss.mode = 1'b0; buss.A = '0; buss.B = '0;
        tick();
        tick();
        check("reset_S",   64'(bus4.S),         64'd0);
        check("reset_C",   64'(bus4.C),         64'd0);
        check("reset_ov",  64'(bus4.out_valid), 64'd0);
        check("reset_cnt", 64'(bus4.carry_cnt), 64'd0);
        rst_n = 1'b1;

        // Single-bit truth table on consecutive cycles.
        for (int k = 0; k < 4; k++) begin
            bus1.in_valid = 1'b1;
            bus1.A = pairs_ab[k][1];
            bus1.B = pairs_ab[k][0];
            tick();
            check($sformatf("w1_S[%0d]", k),  64'(bus1.S),         64'(exp1_s[k]));
            check($sformatf("w1_C[%0d]", k),  64'(bus1.C),         64'(exp1_c[k]));
            check($sformatf("w1_ov[%0d]", k), 64'(bus1.out_valid), 64'd1);
        end
        bus1.in_valid = 1'b0;
        check("w1_cnt", 64'(bus1.carry_cnt), 64'd1);

        // Two-bit counter saturates at 3.
        for (int k = 0; k < 4; k++) begin
            buss.in_valid = 1'b1;
            buss.A = 1'b1;
            buss.B = 1'b1;
            tick();
            check($sformatf("sat_cnt[%0d]", k), 64'(buss.carry_cnt), (k < 3) ? 64'(k + 1) : 64'd3);
        end
        buss.in_valid = 1'b0;

        // Four-lane vectors: both modes, hold, reset priority.
        for (int k = 0; k < 9; k++) begin
            rst_n         = vecs[k].rst_n;
            bus4.in_valid = vecs[k].in_valid;
            bus4.mode     = vecs[k].mode;
            bus4.A        = vecs[k].a;
            bus4.B        = vecs[k].b;
            tick();
            check($sformatf("vec%0d_S", k),   64'(bus4.S),         64'(vecs[k].exp_s));
            check($sformatf("vec%0d_C", k),   64'(bus4.C),         64'(vecs[k].exp_c));
            check($sformatf("vec%0d_ov", k),  64'(bus4.out_valid), 64'(vecs[k].exp_ov));
            check($sformatf("vec%0d_cnt", k), 64'(bus4.carry_cnt), 64'(vecs[k].exp_cnt));
        end
        rst_n = 1'b1;

        // Random traffic on the 4-lane and 1-lane instances with occasional reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m4_s = '0; m4_c = '0; m4_ov = 1'b0; m4_cnt = 0;
        m1_s = 1'b0; m1_c = 1'b0; m1_ov = 1'b0; m1_cnt = 0;
        for (int n = 0; n < 300; n++) begin
            rst_n         = ($urandom_range(0, 24) != 0);
            bus4.in_valid = ($urandom_range(0, 3) != 0);
            bus4.mode     = 1'($urandom_range(0, 1));
            bus4.A        = 4'($urandom);
            bus4.B        = 4'($urandom);
            bus1.in_valid = ($urandom_range(0, 3) != 0);
            bus1.mode     = 1'($urandom_range(0, 1));
            bus1.A        = 1'($urandom);
            bus1.B        = 1'($urandom);

            if (!rst_n) begin
                m4_s = '0; m4_c = '0; m4_ov = 1'b0; m4_cnt = 0;
                m1_s = 1'b0; m1_c = 1'b0; m1_ov = 1'b0; m1_cnt = 0;
            end else begin
                m4_ov = bus4.in_valid;
                if (bus4.in_valid) begin
                    r = ref_add(64'(bus4.A), 64'(bus4.B), bus4.mode, 4);
                    m4_s = r[3:0];
                    m4_c = r[67:64];
                    if (m4_c != 0 && m4_cnt < 65535) m4_cnt++;
                end
                m1_ov = bus1.in_valid;
                if (bus1.in_valid) begin
                    r = ref_add(64'(bus1.A), 64'(bus1.B), bus1.mode, 1);
                    m1_s = r[0];
                    m1_c = r[64];
                    if (m1_c && m1_cnt < 65535) m1_cnt++;
                end
            end
            tick();
            check("rnd4_S",   64'(bus4.S),         64'(m4_s));
            check("rnd4_C",   64'(bus4.C),         64'(m4_c));
            check("rnd4_ov",  64'(bus4.out_valid), 64'(m4_ov));
            check("rnd4_cnt", 64'(bus4.carry_cnt), 64'(m4_cnt));
            check("rnd1_S",   64'(bus1.S),         64'(m1_s));
            check("rnd1_C",   64'(bus1.C),         64'(m1_c));
            check("rnd1_ov",  64'(bus1.out_valid), 64'(m1_ov));
            check("rnd1_cnt", 64'(bus1.carry_cnt), 64'(m1_cnt));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_meio_somador
`default_nettype wire

// File: doc/meio_somador.md
Name: meio_somador

Overview:
- Registered, lane-parallel half-adder block.
- Each lane computes sum (XOR) and carry (AND) of two input bits.
- An optional chained mode ripples lane carries so the lanes act as one WIDTH-bit adder.
- Sits at the bottom of the arithmetic datapath as the basic add primitive; WIDTH=1 gives the classic single-bit half adder with one-cycle latency.

Parameters:
- WIDTH, 1, number of lanes (bits) in A, B, S, C; legal range 1..64.
- CNT_W, 16, width of the carry-event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  qualifies A, B, mode for this cycle.
- mode  input  1  0 = independent lanes; 1 = chained ripple add.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- S  output  WIDTH  registered sum.
- C  output  WIDTH  registered carry vector; bit i = carry out of lane i.
- out_valid  output  1  S/C hold the result of an accepted operation.
- carry_cnt  output  CNT_W  count of accepted operations with any C bit set.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. All state updates on the rising edge of clk.
- Reset: when rst_n=0 at a clock edge, S=0, C=0, out_valid=0, carry_cnt=0. Reset has priority over in_valid.
- Acceptance: when in_valid=1 at an edge, the operands are accepted.
  - Results appear on S/C at that edge, i.e. one-cycle latency.
  - out_valid=1 for exactly that following cycle.
- No backpressure: the block accepts every cycle.
- When in_valid=0: S/C hold their previous values and out_valid=0.
- Mode 0 (independent lanes), per lane i:
  - S[i] = A[i] XOR B[i]
  - C[i] = A[i] AND B[i]
- Mode 1 (chained), per lane i, with c[-1]=0:
  - S[i] = A[i] XOR B[i] XOR c[i-1]
  - c[i] = (A[i] AND B[i]) OR ((A[i] XOR B[i]) AND c[i-1])
  - C[i] = c[i]
  - S is the low WIDTH bits of A+B; C[WIDTH-1] is the overall carry out.
- With WIDTH=1 both modes give identical results.
- carry_cnt: increments by 1 on each accepted operation whose computed C is nonzero. It saturates at all-ones and does not wrap.
- Simultaneous reset and in_valid: reset wins; the operation is dropped.
- Reset mid-stream: a result in flight is discarded; out_valid is 0 on the cycle after reset.
- No X propagation: S, C, out_valid and carry_cnt are defined from the first reset onward.

Decomposition:
- Shared package: MODE_LANES=1'b0 and MODE_CHAIN=1'b1 constants, plus a default CNT_W constant.
- Natural sub-module: half_adder_cell (combinational, 1-bit A/B/cin/chain_en -> s, cout), instantiated WIDTH times via generate. The top level holds the registers, valid pipeline and saturating counter.

Test Plan:
- WIDTH=1: reset, then apply A,B = 0,0 / 0,1 / 1,0 / 1,1 with in_valid=1 on consecutive cycles -> one cycle later S,C = 0,0 / 1,0 / 1,0 / 0,1; out_valid=1 each cycle; carry_cnt=1 at end.
- WIDTH=4, mode=0, A=4'b0111, B=4'b0001 -> S=4'b0110, C=4'b0001 next cycle.
- WIDTH=4, mode=1, A=4'b0111, B=4'b0001 -> S=4'b1000, C=4'b0111. Then A=4'b1111, B=4'b0001 -> S=4'b0000, C=4'b1111, with carry out bit 3 set.
- Hold: after a valid op, drive in_valid=0 for 3 cycles with changing A/B -> S/C unchanged, out_valid=0, carry_cnt unchanged.
- Reset priority: rst_n=0 together with in_valid=1, A=B=1 -> next cycle S=0, C=0, out_valid=0, carry_cnt=0.
- Saturation: CNT_W=2, four accepted ops with A=B=1 -> carry_cnt goes 1, 2, 3, 3.
